// File: rtl/rfr_pkg.sv
// Shared constants for the ROM -> FIFO -> RAM sequencer: default widths,
// top-FSM encoding and the counter-width helper.
package rfr_pkg;
  localparam int RFR_DATA_W = 32;
  localparam int RFR_ADDR_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    FINISH = ST_FINISH
  } state_e;

  // Bits needed to hold values 0..v-1; called with NUM_WORDS+1.
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rom_fifo_ram_ctrl_if.sv
// Bundle of the ROM, FIFO and RAM side signals; master is the sequencer.
interface rom_fifo_ram_ctrl_if import rfr_pkg::*; #(
  parameter int DATA_W = RFR_DATA_W,
  parameter int ADDR_W = RFR_ADDR_W
) ();
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              fifo_wreq;
  logic [DATA_W-1:0] fifo_in;
  logic              fifo_wrfull;
  logic              fifo_rdreq;
  logic [DATA_W-1:0] fifo_out;
  logic              fifo_rdempty;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  modport master (
    output rom_en, rom_addr, fifo_wreq, fifo_in, fifo_rdreq, ram_we, ram_addr, ram_din,
    input  rom_data, fifo_wrfull, fifo_out, fifo_rdempty
  );
  modport slave (
    input  rom_en, rom_addr, fifo_wreq, fifo_in, fifo_rdreq, ram_we, ram_addr, ram_din,
    output rom_data, fifo_wrfull, fifo_out, fifo_rdempty
  );
endinterface

// File: rtl/rfr_fill_skid.sv
// ROM issue logic plus a one-entry skid register in front of the FIFO write port.
module rfr_fill_skid import rfr_pkg::*; #(
  parameter int DATA_W    = RFR_DATA_W,
  parameter int ADDR_W    = RFR_ADDR_W,
  parameter int NUM_WORDS = 16,
  parameter int ROM_BASE  = 0,
  parameter int CNT_W     = clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic              fifo_wrfull_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              issue_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              fifo_wreq_o,
  output logic [DATA_W-1:0] fifo_in_o,
  output logic [CNT_W-1:0]  acc_cnt_o
);
  logic [CNT_W-1:0]  issue_cnt_q, acc_cnt_q;
  logic              pend_q, hold_vld_q;
  logic [DATA_W-1:0] hold_q;

  always_comb begin
    // A read returning into a full FIFO lands in the hold register, so
    // issuing stops until that slot has drained.
    issue_en_o  = run_i && (issue_cnt_q < CNT_W'(NUM_WORDS)) && !fifo_wrfull_i &&
                  !hold_vld_q && !(pend_q && fifo_wrfull_i);
    rom_addr_o  = issue_en_o ? ADDR_W'(ROM_BASE) + ADDR_W'(issue_cnt_q) : '0;
    fifo_wreq_o = (hold_vld_q || pend_q) && !fifo_wrfull_i;
    fifo_in_o   = !fifo_wreq_o ? '0 : (hold_vld_q ? hold_q : rom_data_i);
    acc_cnt_o   = acc_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      pend_q      <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (clr_i) begin
        issue_cnt_q <= '0;
        acc_cnt_q   <= '0;
      end else begin
        if (issue_en_o)  issue_cnt_q <= issue_cnt_q + 1'b1;
        if (fifo_wreq_o) acc_cnt_q   <= acc_cnt_q + 1'b1;
      end
      pend_q <= issue_en_o;
      if (pend_q && fifo_wrfull_i) begin
        hold_vld_q <= 1'b1;
        hold_q     <= rom_data_i;
      end else if (hold_vld_q && !fifo_wrfull_i) begin
        hold_vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rom_fifo_ram_ctrl.sv
// Sequencer: streams NUM_WORDS ROM words into the FIFO while draining the
// FIFO into consecutive RAM addresses, then pulses done.
module rom_fifo_ram_ctrl import rfr_pkg::*; #(
  parameter int DATA_W    = RFR_DATA_W,
  parameter int ADDR_W    = RFR_ADDR_W,
  parameter int NUM_WORDS = 16,
  parameter int ROM_BASE  = 0,
  parameter int RAM_BASE  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  rom_fifo_ram_ctrl_if.master bus
);
  localparam int CNT_W = clog2(NUM_WORDS + 1);

  state_e            state_q, state_d;
  logic              run, clr, rdreq, ram_we_q;
  logic              issue_en, wreq;
  logic [ADDR_W-1:0] rom_addr, ram_addr_q;
  logic [DATA_W-1:0] fifo_in;
  logic [CNT_W-1:0]  rd_cnt, req_cnt_q, wr_cnt_q;

  assign run  = (state_q == RUN);
  assign clr  = (state_q == IDLE) && start;
  assign busy = run;
  assign done = (state_q == FINISH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_cnt == CNT_W'(NUM_WORDS) && wr_cnt_q == CNT_W'(NUM_WORDS))
                 state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  rfr_fill_skid #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS),
    .ROM_BASE(ROM_BASE), .CNT_W(CNT_W)
  ) u_fill (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .run_i(run),
    .fifo_wrfull_i(bus.fifo_wrfull), .rom_data_i(bus.rom_data),
    .issue_en_o(issue_en), .rom_addr_o(rom_addr),
    .fifo_wreq_o(wreq), .fifo_in_o(fifo_in), .acc_cnt_o(rd_cnt)
  );

  assign rdreq = run && (req_cnt_q < CNT_W'(NUM_WORDS)) && !bus.fifo_rdempty;

  // The RAM address is latched at the read request, so it lines up with
  // fifo_out one cycle later and holds between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      if (clr) begin
        req_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end else begin
        if (rdreq)    req_cnt_q <= req_cnt_q + 1'b1;
        if (ram_we_q) wr_cnt_q  <= wr_cnt_q + 1'b1;
      end
      ram_we_q <= rdreq;
      if (rdreq) ram_addr_q <= ADDR_W'(RAM_BASE) + ADDR_W'(req_cnt_q);
    end
  end

  assign bus.rom_en     = issue_en;
  assign bus.rom_addr   = rom_addr;
  assign bus.fifo_wreq  = wreq;
  assign bus.fifo_in    = fifo_in;
  assign bus.fifo_rdreq = rdreq;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_din    = ram_we_q ? bus.fifo_out : '0;
endmodule

// File: tb/tb_rom_fifo_ram_ctrl.sv
// Directed bench: two sequencer instances (16 words base 0; 8 words into RAM base 8)
// against behavioural ROM / FIFO / RAM-write models.
module tb_rom_fifo_ram_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic busy0, done0, busy1, done1;
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  rom_fifo_ram_ctrl_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
  rom_fifo_ram_ctrl_if #(.DATA_W(32), .ADDR_W(4)) b1 ();

  rom_fifo_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(16), .ROM_BASE(0), .RAM_BASE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .bus(b0));
  rom_fifo_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(8), .ROM_BASE(0), .RAM_BASE(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .bus(b1));

  // ---------------- models for instance 0 ----------------
  logic [31:0] rom_q0 = '0, fout0 = '0;
  logic [31:0] q0[$], wlog0[$], dlog0[$];
  int          alog0[$], wcyc0[$];
  int          cnt0 = 0, ff0 = 0, fe0 = 0, ndone0 = 0, viol0 = 0, cyc = 0;
  logic        rdreq_d0 = 1'b0, busy_p0 = 1'b0, bp_arm = 1'b0, st_arm = 1'b0;

  assign b0.rom_data     = rom_q0;
  assign b0.fifo_out     = fout0;
  assign b0.fifo_wrfull  = (ff0 != 0) || (cnt0 >= 16);
  assign b0.fifo_rdempty = (fe0 != 0) || (cnt0 == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b0.rom_en) rom_q0 <= 32'hA5A5_0000 + 32'(b0.rom_addr);
    if (!rst_n) begin
      q0.delete();
      cnt0 <= 0; ff0 <= 0; fe0 <= 0; rdreq_d0 <= 1'b0; busy_p0 <= 1'b0;
    end else begin
      if (b0.fifo_wreq) begin
        q0.push_back(b0.fifo_in);
        wlog0.push_back(b0.fifo_in);
        wcyc0.push_back(cyc);
      end
      if (b0.fifo_rdreq && q0.size() > 0) fout0 <= q0.pop_front();
      cnt0 <= cnt0 + int'(b0.fifo_wreq) - int'(b0.fifo_rdreq);
      if (b0.ram_we) begin
        alog0.push_back(int'(b0.ram_addr));
        dlog0.push_back(b0.ram_din);
      end
      if (done0) ndone0 <= ndone0 + 1;
      viol0 <= viol0 + int'(b0.fifo_wreq && b0.fifo_wrfull) + int'(b0.fifo_rdreq && b0.fifo_rdempty)
                     + int'(b0.ram_we !== rdreq_d0) + int'(done0 && busy0) + int'(done0 && !busy_p0)
                     + int'(b0.rom_en && ff0 != 0) + int'(b0.fifo_rdreq && fe0 != 0);
      rdreq_d0 <= b0.fifo_rdreq;
      busy_p0  <= busy0;
      if (bp_arm && b0.rom_en && b0.rom_addr == 4'd3) ff0 <= 5;
      else if (ff0 != 0) ff0 <= ff0 - 1;
      if (st_arm && b0.ram_we && b0.ram_addr == 4'd4) fe0 <= 10;
      else if (fe0 != 0) fe0 <= fe0 - 1;
    end
  end

  // ---------------- models for instance 1 ----------------
  logic [31:0] rom_q1 = '0, fout1 = '0;
  logic [31:0] q1[$], dlog1[$];
  int          alog1[$];
  int          cnt1 = 0, ndone1 = 0, viol1 = 0;
  logic        rdreq_d1 = 1'b0;

  assign b1.rom_data     = rom_q1;
  assign b1.fifo_out     = fout1;
  assign b1.fifo_wrfull  = (cnt1 >= 16);
  assign b1.fifo_rdempty = (cnt1 == 0);

  always @(posedge clk) begin
    if (b1.rom_en) rom_q1 <= 32'hA5A5_0000 + 32'(b1.rom_addr);
    if (!rst_n) begin
      q1.delete();
      cnt1 <= 0; rdreq_d1 <= 1'b0;
    end else begin
      if (b1.fifo_wreq) q1.push_back(b1.fifo_in);
      if (b1.fifo_rdreq && q1.size() > 0) fout1 <= q1.pop_front();
      cnt1 <= cnt1 + int'(b1.fifo_wreq) - int'(b1.fifo_rdreq);
      if (b1.ram_we) begin
        alog1.push_back(int'(b1.ram_addr));
        dlog1.push_back(b1.ram_din);
      end
      if (done1) ndone1 <= ndone1 + 1;
      viol1 <= viol1 + int'(b1.fifo_wreq && b1.fifo_wrfull) + int'(b1.fifo_rdreq && b1.fifo_rdempty)
                     + int'(b1.ram_we !== rdreq_d1) + int'(done1 && busy1);
      rdreq_d1 <= b1.fifo_rdreq;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // poke: pulse start twice while busy and once in the done cycle
  task automatic xfer0(input string tag, input bit poke);
    int nd;
    nd = ndone0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk({tag, "_busy"}, 64'(busy0), 64'd1);
    for (int i = 0; i < 400 && ndone0 == nd; i++) begin
      start0 = poke && (i == 3 || i == 9 || done0 === 1'b1);
      @(negedge clk);
    end
    start0 = 1'b0;
    chk({tag, "_done"}, 64'(ndone0 - nd), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_once"}, 64'(ndone0 - nd), 64'd1);
    chk({tag, "_idle"}, 64'(busy0), 64'd0);
  endtask

  task automatic xfer1(input string tag);
    int nd;
    nd = ndone1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 400 && ndone1 == nd; i++) @(negedge clk);
    chk({tag, "_done"}, 64'(ndone1 - nd), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_once"}, 64'(ndone1 - nd), 64'd1);
  endtask

  // 16 words ROM[0..15] in order into the FIFO and into RAM[0..15]
  task automatic check_xfer0(input string tag, input int wb, input int ab);
    chk({tag, "_nwr"}, 64'(wlog0.size() - wb), 64'd16);
    chk({tag, "_nram"}, 64'(alog0.size() - ab), 64'd16);
    for (int k = 0; k < 16; k++) begin
      if (wb + k < wlog0.size())
        chk($sformatf("%s_fifo%0d", tag, k), 64'(wlog0[wb+k]), 64'(32'hA5A5_0000 + k));
      if (ab + k < alog0.size()) begin
        chk($sformatf("%s_addr%0d", tag, k), 64'(alog0[ab+k]), 64'(k));
        chk($sformatf("%s_ram%0d", tag, k), 64'(dlog0[ab+k]), 64'(32'hA5A5_0000 + k));
      end
    end
  endtask

  initial begin
    int wb, ab;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl",  64'({busy0, done0, b0.rom_en, b0.fifo_wreq, b0.fifo_rdreq, b0.ram_we}), 64'd0);
    chk("rst_addr", 64'({b0.rom_addr, b0.ram_addr}), 64'd0);
    chk("rst_data", {b0.fifo_in, b0.ram_din}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // free flow, with starts while busy and in the done cycle
    wb = wlog0.size(); ab = alog0.size();
    xfer0("flow", 1'b1);
    check_xfer0("flow", wb, ab);
    if (wcyc0.size() >= wb + 16) chk("flow_rate", 64'(wcyc0[wb+15] - wcyc0[wb]), 64'd15);
    chk("flow_last", 64'(alog0[alog0.size()-1]), 64'd15);

    // back-pressure around word 3
    wb = wlog0.size(); ab = alog0.size();
    bp_arm = 1'b1;
    xfer0("bp", 1'b0);
    bp_arm = 1'b0;
    check_xfer0("bp", wb, ab);
    if (wcyc0.size() >= wb + 16) chk("bp_span", 64'(wcyc0[wb+15] - wcyc0[wb]), 64'd21);

    // drain starvation
    wb = wlog0.size(); ab = alog0.size();
    st_arm = 1'b1;
    xfer0("starve", 1'b0);
    st_arm = 1'b0;
    check_xfer0("starve", wb, ab);

    // second instance: two back-to-back transfers into RAM[8..15]
    xfer1("r1a");
    xfer1("r1b");
    chk("r1_nram", 64'(alog1.size()), 64'd16);
    for (int k = 0; k < 16 && k < alog1.size(); k++) begin
      chk($sformatf("r1_addr%0d", k), 64'(alog1[k]), 64'(8 + (k % 8)));
      chk($sformatf("r1_ram%0d", k), 64'(dlog1[k]), 64'(32'hA5A5_0000 + (k % 8)));
    end

    // reset after 6 RAM writes, then a full fresh transfer
    ab = alog0.size();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 200 && alog0.size() - ab < 6; i++) @(negedge clk);
    chk("mid_six", 64'(alog0.size() - ab), 64'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_ctl",  64'({busy0, done0, b0.rom_en, b0.fifo_wreq, b0.fifo_rdreq, b0.ram_we}), 64'd0);
    chk("mid_addr", 64'({b0.rom_addr, b0.ram_addr}), 64'd0);
    chk("mid_data", {b0.fifo_in, b0.ram_din}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb = wlog0.size(); ab = alog0.size();
    xfer0("again", 1'b0);
    check_xfer0("again", wb, ab);

    chk("proto0", 64'(viol0), 64'd0);
    chk("proto1", 64'(viol1), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
